// File: rtl/wb_stage.sv
// Writeback stage: retires M-stage instructions, aligns load data and
// drives a registered single-cycle write into the register file.
module wb_stage #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic             m_reg_we,
    input  logic [4:0]       m_rd_addr,
    input  logic [1:0]       m_wb_sel,
    input  logic [2:0]       m_funct3,
    input  logic [31:0]      m_alu_result,
    input  logic [31:0]      m_pc_plus4,
    input  logic [31:0]      m_csr_rdata,
    input  logic             dmem_resp_valid,
    input  logic [31:0]      dmem_resp_data,
    output logic             rf_we,
    output logic [4:0]       rf_wb_addr,
    output logic [31:0]      rf_wb_data,
    output logic             load_pending,
    output logic [4:0]       load_pending_rd,
    output logic             load_err,
    output logic [CNT_W-1:0] retire_count
);

    localparam int TW = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    state_t         state;
    logic [TW-1:0]  tcnt;
    logic [4:0]     ld_rd;
    logic           ld_we;
    logic [2:0]     ld_f3;
    logic [1:0]     ld_off;

    logic [31:0]    sel_data;
    logic [31:0]    ld_data;
    logic           ld_bad;
    logic [7:0]     lb;
    logic [15:0]    lh;

    assign m_ready         = (state == IDLE);
    assign load_pending    = (state == WAIT_LOAD);
    assign load_pending_rd = load_pending ? ld_rd : 5'd0;

    always_comb begin
        sel_data = m_alu_result;
        unique case (m_wb_sel)
            2'b10:   sel_data = m_pc_plus4;
            2'b11:   sel_data = m_csr_rdata;
            default: sel_data = m_alu_result;
        endcase
    end

    assign lb = dmem_resp_data[8*ld_off +: 8];
    assign lh = ld_off[1] ? dmem_resp_data[31:16] : dmem_resp_data[15:0];

    // Misalignment is judged on the latched offset when the response lands
    always_comb begin
        ld_bad  = 1'b0;
        ld_data = dmem_resp_data;
        unique case (ld_f3)
            3'b000: ld_data = {{24{lb[7]}}, lb};
            3'b001: begin
                ld_data = {{16{lh[15]}}, lh};
                ld_bad  = ld_off[0];
            end
            3'b010: ld_bad = |ld_off;
            3'b100: ld_data = {24'd0, lb};
            3'b101: begin
                ld_data = {16'd0, lh};
                ld_bad  = ld_off[0];
            end
            default: ld_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            tcnt         <= '0;
            ld_rd        <= 5'd0;
            ld_we        <= 1'b0;
            ld_f3        <= 3'd0;
            ld_off       <= 2'd0;
            rf_we        <= 1'b0;
            rf_wb_addr   <= 5'd0;
            rf_wb_data   <= 32'd0;
            load_err     <= 1'b0;
            retire_count <= '0;
        end else begin
            rf_we    <= 1'b0;
            load_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m_valid) begin
                        if (m_wb_sel == 2'b01) begin
                            ld_rd  <= m_rd_addr;
                            ld_we  <= m_reg_we;
                            ld_f3  <= m_funct3;
                            ld_off <= m_alu_result[1:0];
                            tcnt   <= '0;
                            state  <= WAIT_LOAD;
                        end else begin
                            retire_count <= retire_count + 1'b1;
                            if (m_reg_we && m_rd_addr != 5'd0) begin
                                rf_we      <= 1'b1;
                                rf_wb_addr <= m_rd_addr;
                                rf_wb_data <= sel_data;
                            end
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (dmem_resp_valid) begin
                        state        <= IDLE;
                        retire_count <= retire_count + 1'b1;
                        if (ld_bad) begin
                            load_err <= 1'b1;
                        end else if (ld_we && ld_rd != 5'd0) begin
                            rf_we      <= 1'b1;
                            rf_wb_addr <= ld_rd;
                            rf_wb_data <= ld_data;
                        end
                    end else if (tcnt == TW'(LOAD_TIMEOUT - 1)) begin
                        state    <= IDLE;
                        load_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_wb_stage;

    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic        m_ready;
    logic        m_reg_we;
    logic [4:0]  m_rd_addr;
    logic [1:0]  m_wb_sel;
    logic [2:0]  m_funct3;
    logic [31:0] m_alu_result;
    logic [31:0] m_pc_plus4;
    logic [31:0] m_csr_rdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic        rf_we;
    logic [4:0]  rf_wb_addr;
    logic [31:0] rf_wb_data;
    logic        load_pending;
    logic [4:0]  load_pending_rd;
    logic        load_err;
    logic [31:0] retire_count;

    wb_stage #(.LOAD_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_reg_we(m_reg_we),
        .m_rd_addr(m_rd_addr),
        .m_wb_sel(m_wb_sel),
        .m_funct3(m_funct3),
        .m_alu_result(m_alu_result),
        .m_pc_plus4(m_pc_plus4),
        .m_csr_rdata(m_csr_rdata),
        .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_data(dmem_resp_data),
        .rf_we(rf_we),
        .rf_wb_addr(rf_wb_addr),
        .rf_wb_data(rf_wb_data),
        .load_pending(load_pending),
        .load_pending_rd(load_pending_rd),
        .load_err(load_err),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {err, data} for a load response, straight from the alignment rules
    function automatic logic [32:0] ref_load(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return {1'b0, b[7] ? (b | 32'hFFFFFF00) : b};
            3'd4:    return {1'b0, b};
            3'd1:    return {off[0], h[15] ? (h | 32'hFFFF0000) : h};
            3'd5:    return {off[0], h};
            3'd2:    return {off != 2'd0, w};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Model state: at most one outstanding load, plus expected outputs
    bit          chk_en = 0;
    bit          pend = 0;
    int          age = 0;
    logic [4:0]  p_rd = 0;
    logic        p_we = 0;
    logic [2:0]  p_f3 = 0;
    logic [1:0]  p_off = 0;
    logic        e_we = 0;
    logic [4:0]  e_addr = 0;
    logic [31:0] e_data = 0;
    logic        e_err = 0;
    logic [31:0] e_cnt = 0;

    always @(posedge clk) begin
        logic [32:0] r;
        if (!reset) begin
            pend = 0; age = 0;
            e_we = 0; e_addr = 0; e_data = 0; e_err = 0; e_cnt = 0;
            chk_en = 1;
        end else begin
            e_we = 0;
            e_err = 0;
            if (pend) begin
                if (dmem_resp_valid) begin
                    r = ref_load(p_f3, p_off, dmem_resp_data);
                    pend = 0;
                    e_cnt = e_cnt + 1;
                    if (r[32]) e_err = 1;
                    else if (p_we && p_rd != 0) begin
                        e_we = 1; e_addr = p_rd; e_data = r[31:0];
                    end
                end else begin
                    age++;
                    if (age == TO) begin
                        pend = 0;
                        e_err = 1;
                    end
                end
            end else if (m_valid) begin
                if (m_wb_sel == 2'b01) begin
                    pend = 1; age = 0;
                    p_rd = m_rd_addr; p_we = m_reg_we;
                    p_f3 = m_funct3; p_off = m_alu_result[1:0];
                end else begin
                    e_cnt = e_cnt + 1;
                    if (m_reg_we && m_rd_addr != 0) begin
                        e_we = 1;
                        e_addr = m_rd_addr;
                        e_data = (m_wb_sel == 2'b00) ? m_alu_result :
                                 (m_wb_sel == 2'b10) ? m_pc_plus4 : m_csr_rdata;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ready", {31'd0, m_ready}, {31'd0, !pend});
            check("rf_we", {31'd0, rf_we}, {31'd0, e_we});
            check("rf_wb_addr", {27'd0, rf_wb_addr}, {27'd0, e_addr});
            check("rf_wb_data", rf_wb_data, e_data);
            check("load_err", {31'd0, load_err}, {31'd0, e_err});
            check("retire_count", retire_count, e_cnt);
            check("load_pending", {31'd0, load_pending}, {31'd0, pend});
            check("load_pending_rd", {27'd0, load_pending_rd},
                  {27'd0, pend ? p_rd : 5'd0});
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] pc);
        m_valid = 1; m_reg_we = 1; m_wb_sel = sel; m_rd_addr = rd;
        m_funct3 = f3; m_alu_result = alu; m_pc_plus4 = pc;
        m_csr_rdata = 32'hC5C5C5C5;
        cyc();
        m_valid = 0;
    endtask

    task automatic respond(input logic [31:0] d);
        dmem_resp_valid = 1; dmem_resp_data = d;
        cyc();
        dmem_resp_valid = 0;
    endtask

    initial begin
        logic [32:0] t;
        reset = 0; m_valid = 0; m_reg_we = 0; m_rd_addr = 0; m_wb_sel = 0;
        m_funct3 = 0; m_alu_result = 0; m_pc_plus4 = 0; m_csr_rdata = 0;
        dmem_resp_valid = 0; dmem_resp_data = 0;

        t = ref_load(3'd0, 2'd3, 32'h80FF0000);
        check("model_lb", t[31:0], 32'hFFFFFF80);
        t = ref_load(3'd5, 2'd2, 32'h80011234);
        check("model_lhu", t[31:0], 32'h00008001);

        cyc(); cyc();
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_retire", retire_count, 32'd0);
        check("rst_ready", {31'd0, m_ready}, 32'd1);
        reset = 1;
        cyc();

        issue(2'b00, 5'd5, 3'd0, 32'hDEADBEEF, 32'h0);
        check("alu_we", {31'd0, rf_we}, 32'd1);
        check("alu_addr", {27'd0, rf_wb_addr}, 32'd5);
        check("alu_data", rf_wb_data, 32'hDEADBEEF);
        check("alu_cnt", retire_count, 32'd1);
        cyc();
        check("alu_we_pulse", {31'd0, rf_we}, 32'd0);

        issue(2'b01, 5'd7, 3'd0, 32'h00001003, 32'h0);
        check("lb_ready", {31'd0, m_ready}, 32'd0);
        check("lb_pend_rd", {27'd0, load_pending_rd}, 32'd7);
        cyc();
        check("lb_ready2", {31'd0, m_ready}, 32'd0);
        respond(32'h80FF0000);
        check("lb_data", rf_wb_data, 32'hFFFFFF80);
        check("lb_cnt", retire_count, 32'd2);

        issue(2'b01, 5'd8, 3'd4, 32'h00001003, 32'h0);
        cyc();
        respond(32'h80FF0000);
        check("lbu_data", rf_wb_data, 32'h00000080);

        issue(2'b01, 5'd9, 3'd1, 32'h00002002, 32'h0);
        respond(32'h80011234);
        check("lh_data", rf_wb_data, 32'hFFFF8001);

        issue(2'b01, 5'd10, 3'd2, 32'h00002001, 32'h0);
        respond(32'h12345678);
        check("lw_mis_err", {31'd0, load_err}, 32'd1);
        check("lw_mis_we", {31'd0, rf_we}, 32'd0);
        check("lw_mis_cnt", retire_count, 32'd5);

        issue(2'b10, 5'd0, 3'd0, 32'h0, 32'h00000104);
        check("rd0_we", {31'd0, rf_we}, 32'd0);
        check("rd0_cnt", retire_count, 32'd6);

        issue(2'b01, 5'd11, 3'd2, 32'h00003000, 32'h0);
        repeat (TO - 1) cyc();
        check("to_still_pend", {31'd0, load_pending}, 32'd1);
        cyc();
        check("to_err", {31'd0, load_err}, 32'd1);
        check("to_ready", {31'd0, m_ready}, 32'd1);
        check("to_cnt", retire_count, 32'd6);

        issue(2'b01, 5'd3, 3'd2, 32'h00004000, 32'h0);
        reset = 0;
        cyc();
        reset = 1;
        check("rst_wait_cnt", retire_count, 32'd0);
        check("rst_wait_pend", {31'd0, load_pending}, 32'd0);
        respond(32'h12345678);
        check("rst_wait_we", {31'd0, rf_we}, 32'd0);

        repeat (4000) begin
            m_valid = ($urandom_range(0, 1) == 1);
            m_reg_we = ($urandom_range(0, 7) != 0);
            m_rd_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            m_wb_sel = 2'($urandom);
            m_funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom)
                     : (($urandom_range(0, 1) == 1) ? 3'd0 : 3'd4);
            m_alu_result = $urandom;
            m_pc_plus4 = $urandom;
            m_csr_rdata = $urandom;
            dmem_resp_valid = ($urandom_range(0, 3) == 0);
            dmem_resp_data = $urandom;
            reset = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
